// File: rtl/ahb_param_arbiter_if.sv
// Bus-side signal bundle between the AHB master agents and the arbiter.
// Requests, lock and the muxed slave response flow into the arbiter;
// grant and address-phase ownership flow back out to masters and slaves.
interface ahb_param_arbiter_if #(
   parameter int NUM_MASTERS = 4
) ();

   logic [NUM_MASTERS-1:0] busreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic [1:0]             htrans;
   logic [2:0]             hburst;
   logic                   hready;
   logic [1:0]             hresp;
   logic [NUM_MASTERS-1:0] hsplit;

   logic [NUM_MASTERS-1:0] hgrant;
   logic [3:0]             hmaster;
   logic                   hmastlock;

   // Agent side: raises requests and presents the muxed bus, observes grants.
   modport master (
      output busreq, hlock, htrans, hburst, hready, hresp, hsplit,
      input  hgrant, hmaster, hmastlock
   );

   // Arbiter side.
   modport slave (
      input  busreq, hlock, htrans, hburst, hready, hresp, hsplit,
      output hgrant, hmaster, hmastlock
   );

endinterface

// File: rtl/ahb_param_arbiter.sv
// Parametrised AHB bus arbiter: fixed-priority or round-robin selection,
// burst-aware handover, locked-transfer retention and SPLIT masking/release.
// All outputs come straight from registers.
module ahb_param_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter bit RR_MODE        = 1'b1
) (
   input logic                hclk,
   input logic                hreset,
   ahb_param_arbiter_if.slave bus
);

   localparam logic [1:0] TRANS_NONSEQ = 2'd2;
   localparam logic [1:0] TRANS_SEQ    = 2'd3;
   localparam logic [1:0] RESP_RETRY   = 2'd2;
   localparam logic [1:0] RESP_SPLIT   = 2'd3;

   localparam logic [NUM_MASTERS-1:0] GRANT_RST =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
   localparam logic [3:0] MASTER_RST = 4'(DEFAULT_MASTER);
   // Last winner starts at the top index so master 0 is searched first.
   localparam logic [3:0] LAST_RST   = 4'(NUM_MASTERS - 1);

   logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
   logic [3:0]             hmaster_q, hmaster_d;
   logic                   hmastlock_q, hmastlock_d;
   logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
   logic [3:0]             beats_q, beats_d;
   logic [3:0]             last_q, last_d;

   logic [3:0]             grant_idx;
   logic                   grant_lock;
   logic                   owner_lock;
   logic                   forced_pt;
   logic                   arb_pt;
   logic [NUM_MASTERS-1:0] eligible;
   logic [NUM_MASTERS-1:0] above_last;
   logic [NUM_MASTERS-1:0] split_set;
   logic [3:0]             win_idx;

   // Index of the lowest set bit; callers guarantee vec is non-zero.
   function automatic logic [3:0] lowest_set(input logic [NUM_MASTERS-1:0] vec);
      logic [3:0] idx;
      idx = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (vec[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Decode the one-hot grant and the current owner into index / lock bits.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
      grant_idx  = '0;
      grant_lock = 1'b0;
      owner_lock = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (hgrant_q[i]) begin
            grant_idx  = 4'(i);
            grant_lock = bus.hlock[i];
         end
         if (hmaster_q == 4'(i)) owner_lock = bus.hlock[i];
      end
   end

   // Second SPLIT/RETRY response cycle hands the bus over unconditionally.
   assign forced_pt = bus.hready && (bus.hresp == RESP_RETRY || bus.hresp == RESP_SPLIT);

   // Remaining-beat counter: loaded by a NONSEQ, counted down by SEQ beats.
   always_comb begin
      beats_d = beats_q;
      if (bus.hready) begin
         if (bus.htrans == TRANS_NONSEQ) begin
            case (bus.hburst)
               3'd2, 3'd3: beats_d = 4'd3;
               3'd4, 3'd5: beats_d = 4'd7;
               3'd6, 3'd7: beats_d = 4'd15;
               default:    beats_d = 4'd0;
            endcase
         end else if (bus.htrans == TRANS_SEQ && beats_q != 4'd0) begin
            beats_d = beats_q - 4'd1;
         end
         if (forced_pt) beats_d = 4'd0;
      end
   end

   // The bus may change hands once the burst is done and the owner is unlocked.
   assign arb_pt = forced_pt || (bus.hready && beats_d == 4'd0 && !owner_lock);

   assign eligible = bus.busreq & ~split_mask_q;

   // Winner selection: rotate past the last winner in round-robin mode.
   always_comb begin
      above_last = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         above_last[i] = (4'(i) > last_q);
      end
      if (eligible == '0) begin
         win_idx = MASTER_RST;
      end else if (RR_MODE && (eligible & above_last) != '0) begin
         win_idx = lowest_set(eligible & above_last);
      end else begin
         win_idx = lowest_set(eligible);
      end
   end

   // Next grant, ownership and split-mask values.
   always_comb begin
      hgrant_d = hgrant_q;
      last_d   = last_q;
      if (arb_pt) begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            hgrant_d[i] = (win_idx == 4'(i));
         end
         // A default grant to an idle bus does not move the rotation point.
         if (eligible != '0) last_d = win_idx;
      end

      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
      if (bus.hready) begin
         hmaster_d   = grant_idx;
         hmastlock_d = grant_lock;
      end

      // First SPLIT cycle masks the owner; set beats a same-cycle release.
      split_set = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         split_set[i] = (bus.hresp == RESP_SPLIT) && !bus.hready && (hmaster_q == 4'(i));
      end
      split_mask_d = (split_mask_q & ~bus.hsplit) | split_set;
   end

   // State registers with asynchronous reset to the default-master grant.
   always_ff @(posedge hclk or negedge hreset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (!hreset) begin
         hgrant_q     <= GRANT_RST;
         hmaster_q    <= MASTER_RST;
         hmastlock_q  <= 1'b0;
         split_mask_q <= '0;
         beats_q      <= '0;
         last_q       <= LAST_RST;
      end else begin
         hgrant_q     <= hgrant_d;
         hmaster_q    <= hmaster_d;
         hmastlock_q  <= hmastlock_d;
         split_mask_q <= split_mask_d;
         beats_q      <= beats_d;
         last_q       <= last_d;
      end
   end

   assign bus.hgrant    = hgrant_q;
   assign bus.hmaster   = hmaster_q;
   assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_param_arbiter.sv
// Self-checking bench: one round-robin arbiter (default master 2) and one
// fixed-priority arbiter (default master 0) share the same stimulus. A
// table of vectors, directed multi-cycle sequences and random traffic are
// checked against constants and a behavioural model of the arbitration rules.
module tb_ahb_param_arbiter;

   localparam int N = 4;

   logic         hclk = 1'b0;
   logic         hreset;
   logic [N-1:0] busreq, hlock, hsplit;
   logic [1:0]   htrans, hresp;
   logic [2:0]   hburst;
   logic         hready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 hclk = ~hclk;

   ahb_param_arbiter_if #(.NUM_MASTERS(N)) bus_a ();
   ahb_param_arbiter_if #(.NUM_MASTERS(N)) bus_b ();

   assign bus_a.busreq = busreq;
   assign bus_a.hlock  = hlock;
   assign bus_a.htrans = htrans;
   assign bus_a.hburst = hburst;
   assign bus_a.hready = hready;
   assign bus_a.hresp  = hresp;
   assign bus_a.hsplit = hsplit;
   assign bus_b.busreq = busreq;
   assign bus_b.hlock  = hlock;
   assign bus_b.htrans = htrans;
   assign bus_b.hburst = hburst;
   assign bus_b.hready = hready;
   assign bus_b.hresp  = hresp;
   assign bus_b.hsplit = hsplit;

   ahb_param_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(2), .RR_MODE(1'b1)) dut_rr (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus_a)
   );

   ahb_param_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .RR_MODE(1'b0)) dut_fp (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model (index 0 = rr dut, 1 = fp dut) -------
   int p_def[2] = '{2, 0};
   bit p_rr[2]  = '{1'b1, 1'b0};

   int       m_grant[2];
   int       m_master[2];
   int       m_last[2];
   int       m_beats[2];
   bit       m_mlock[2];
   bit [N-1:0] m_mask[2];

   function automatic bit bit_of(input logic [N-1:0] v, input int i);
      logic [N-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   function automatic logic [N-1:0] one_hot(input int i);
      logic [N-1:0] one;
      one = 1;
      return one << i;
   endfunction

   function automatic int burst_len(input logic [2:0] b);
      if (b >= 3'd6) return 16;
      if (b >= 3'd4) return 8;
      if (b >= 3'd2) return 4;
      return 1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_grant[m]  = p_def[m];
         m_master[m] = p_def[m];
         m_mlock[m]  = 1'b0;
         m_mask[m]   = '0;
         m_beats[m]  = 0;
         m_last[m]   = N - 1;
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         int         remaining;
         bit         forced;
         bit         arb;
         int         winner;
         int         cands[$];
         bit [N-1:0] mask_next;
         cands.delete();
         remaining = m_beats[m];
         forced = hready && (hresp == 2'd2 || hresp == 2'd3);
         if (hready) begin
            if (htrans == 2'd2) remaining = burst_len(hburst) - 1;
            else if (htrans == 2'd3 && remaining > 0) remaining = remaining - 1;
            if (forced) remaining = 0;
         end
         arb = forced || (hready && remaining == 0 && !bit_of(hlock, m_master[m]));
         // Eligible masters listed in the order the policy prefers them.
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = p_rr[m] ? (m_last[m] + k) % N : k - 1;
            if (bit_of(busreq, idx) && !bit_of(m_mask[m], idx)) cands.push_back(idx);
         end
         winner = (cands.size() == 0) ? p_def[m] : cands[0];
         mask_next = m_mask[m] & ~hsplit;
         if (hresp == 2'd3 && !hready) mask_next = mask_next | one_hot(m_master[m]);
         if (hready) begin
            m_mlock[m]  = bit_of(hlock, m_grant[m]);
            m_master[m] = m_grant[m];
         end
         if (arb) begin
            if (cands.size() > 0) m_last[m] = winner;
            m_grant[m] = winner;
         end
         m_mask[m]  = mask_next;
         m_beats[m] = remaining;
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, " rr hgrant"},    32'(bus_a.hgrant),     32'(one_hot(m_grant[0])));
      check({tag, " rr hmaster"},   32'(bus_a.hmaster),    32'(m_master[0]));
      check({tag, " rr hmastlock"}, 32'(bus_a.hmastlock),  32'(m_mlock[0]));
      check({tag, " rr onehot"},    32'($onehot(bus_a.hgrant)), 32'd1);
      check({tag, " fp hgrant"},    32'(bus_b.hgrant),     32'(one_hot(m_grant[1])));
      check({tag, " fp hmaster"},   32'(bus_b.hmaster),    32'(m_master[1]));
      check({tag, " fp hmastlock"}, 32'(bus_b.hmastlock),  32'(m_mlock[1]));
      check({tag, " fp onehot"},    32'($onehot(bus_b.hgrant)), 32'd1);
   endtask

   // ---------------- stimulus helpers --------------------------------------
   task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck,
                        input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                        input logic [1:0] rsp, input logic [N-1:0] spl);
      busreq = req;
      hlock  = lck;
      htrans = tr;
      hburst = bu;
      hready = rdy;
      hresp  = rsp;
      hsplit = spl;
   endtask

   task automatic step(input string tag);
      @(posedge hclk);
      model_step();
      #1;
      compare_model(tag);
   endtask

   task automatic chk_grant(input string tag, input logic [N-1:0] exp_rr, input logic [N-1:0] exp_fp);
      check({tag, " rr hgrant"}, 32'(bus_a.hgrant), 32'(exp_rr));
      check({tag, " fp hgrant"}, 32'(bus_b.hgrant), 32'(exp_fp));
   endtask

   task automatic chk_reset_values(input string tag);
      check({tag, " rr hgrant"},    32'(bus_a.hgrant),    32'(4'b0100));
      check({tag, " rr hmaster"},   32'(bus_a.hmaster),   32'd2);
      check({tag, " rr hmastlock"}, 32'(bus_a.hmastlock), 32'd0);
      check({tag, " fp hgrant"},    32'(bus_b.hgrant),    32'(4'b0001));
      check({tag, " fp hmaster"},   32'(bus_b.hmaster),   32'd0);
      check({tag, " fp hmastlock"}, 32'(bus_b.hmastlock), 32'd0);
   endtask

   // Called just after an active edge: reset lands between clock edges.
   task automatic async_reset(input string tag);
      #2 hreset = 1'b0;
      #1;
      chk_reset_values(tag);
      model_reset();
      drive('0, '0, 2'd0, 3'd0, 1'b1, 2'd0, '0);
      @(negedge hclk);
      hreset = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0] busreq;
      logic [1:0]   htrans;
      logic         hready;
      logic [N-1:0] exp_grant_rr;
      logic [3:0]   exp_master_rr;
      logic [N-1:0] exp_grant_fp;
      logic [3:0]   exp_master_fp;
   } vec_t;

   vec_t vecs[11];

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [1:0] tr_seq[9];
      logic       rdy_seq[9];

      // Round robin from reset then fixed priority / default behaviour.
      vecs[0]  = '{4'b1111, 2'd2, 1'b1, 4'b0001, 4'd2, 4'b0001, 4'd0};
      vecs[1]  = '{4'b1111, 2'd2, 1'b1, 4'b0010, 4'd0, 4'b0001, 4'd0};
      vecs[2]  = '{4'b1111, 2'd2, 1'b1, 4'b0100, 4'd1, 4'b0001, 4'd0};
      vecs[3]  = '{4'b1111, 2'd2, 1'b1, 4'b1000, 4'd2, 4'b0001, 4'd0};
      vecs[4]  = '{4'b1111, 2'd2, 1'b1, 4'b0001, 4'd3, 4'b0001, 4'd0};
      vecs[5]  = '{4'b0110, 2'd2, 1'b1, 4'b0010, 4'd0, 4'b0010, 4'd0};
      vecs[6]  = '{4'b0110, 2'd2, 1'b1, 4'b0100, 4'd1, 4'b0010, 4'd1};
      vecs[7]  = '{4'b0110, 2'd2, 1'b1, 4'b0010, 4'd2, 4'b0010, 4'd1};
      vecs[8]  = '{4'b0000, 2'd2, 1'b1, 4'b0100, 4'd1, 4'b0001, 4'd1};
      vecs[9]  = '{4'b0000, 2'd2, 1'b0, 4'b0100, 4'd1, 4'b0001, 4'd1};
      vecs[10] = '{4'b1000, 2'd0, 1'b1, 4'b1000, 4'd2, 4'b1000, 4'd0};

      hreset = 1'b0;
      drive('0, '0, 2'd0, 3'd0, 1'b1, 2'd0, '0);
      @(negedge hclk);
      @(negedge hclk);
      chk_reset_values("reset");
      model_reset();
      hreset = 1'b1;

      // ---- table-driven vectors ----
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].busreq, '0, vecs[i].htrans, 3'd0, vecs[i].hready, 2'd0, '0);
         step($sformatf("vec%0d", i));
         check($sformatf("vec%0d tbl rr hgrant", i),  32'(bus_a.hgrant),  32'(vecs[i].exp_grant_rr));
         check($sformatf("vec%0d tbl rr hmaster", i), 32'(bus_a.hmaster), 32'(vecs[i].exp_master_rr));
         check($sformatf("vec%0d tbl fp hgrant", i),  32'(bus_b.hgrant),  32'(vecs[i].exp_grant_fp));
         check($sformatf("vec%0d tbl fp hmaster", i), 32'(bus_b.hmaster), 32'(vecs[i].exp_master_fp));
      end

      // ---- INCR8 by master 3 with one wait state, master 0 requesting ----
      drive(4'b1000, '0, 2'd0, 3'd0, 1'b1, 2'd0, '0);
      step("incr8 pre");
      check("incr8 pre fp hmaster", 32'(bus_b.hmaster), 32'd3);
      tr_seq  = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
      rdy_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) begin
         drive(4'b1001, '0, tr_seq[i], 3'd5, rdy_seq[i], 2'd0, '0);
         step($sformatf("incr8 beat%0d", i));
         if (i == 8) chk_grant($sformatf("incr8 beat%0d", i), 4'b0001, 4'b0001);
         else        chk_grant($sformatf("incr8 beat%0d", i), 4'b1000, 4'b1000);
      end

      // ---- master 1 locked across three INCR4 bursts, master 0 requesting ----
      drive(4'b0010, 4'b0010, 2'd0, 3'd0, 1'b1, 2'd0, '0);
      step("lock grant");
      step("lock own");
      chk_grant("lock own", 4'b0010, 4'b0010);
      check("lock own fp hmaster", 32'(bus_b.hmaster), 32'd1);
      check("lock own fp hmastlock", 32'(bus_b.hmastlock), 32'd1);
      for (int b = 0; b < 3; b++) begin
         for (int s = 0; s < 4; s++) begin
            drive(4'b0011, 4'b0010, (s == 0) ? 2'd2 : 2'd3, 3'd3, 1'b1, 2'd0, '0);
            step($sformatf("lock b%0d s%0d", b, s));
            chk_grant($sformatf("lock b%0d s%0d", b, s), 4'b0010, 4'b0010);
            check($sformatf("lock b%0d s%0d fp hmastlock", b, s), 32'(bus_b.hmastlock), 32'd1);
         end
      end
      drive(4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, '0);
      step("lock drop");
      chk_grant("lock drop", 4'b0001, 4'b0001);
      check("lock drop fp hmastlock", 32'(bus_b.hmastlock), 32'd0);

      // ---- SPLIT of master 2, default grant, release by hsplit ----
      drive(4'b0100, '0, 2'd0, 3'd0, 1'b1, 2'd0, '0);
      step("split grant");
      step("split own");
      check("split own fp hmaster", 32'(bus_b.hmaster), 32'd2);
      drive(4'b0100, '0, 2'd0, 3'd0, 1'b0, 2'd3, '0);
      step("split c1");
      chk_grant("split c1", 4'b0100, 4'b0100);
      drive(4'b0100, '0, 2'd0, 3'd0, 1'b1, 2'd3, '0);
      step("split c2");
      chk_grant("split c2", 4'b0100, 4'b0001);
      for (int i = 0; i < 2; i++) begin
         drive(4'b0100, '0, 2'd0, 3'd0, 1'b1, 2'd0, '0);
         step($sformatf("split masked%0d", i));
         chk_grant($sformatf("split masked%0d", i), 4'b0100, 4'b0001);
      end
      drive(4'b0100, '0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0100);
      step("split release");
      chk_grant("split release", 4'b0100, 4'b0001);
      drive(4'b0100, '0, 2'd0, 3'd0, 1'b1, 2'd0, '0);
      step("split regrant");
      chk_grant("split regrant", 4'b0100, 4'b0100);

      // ---- split race: release and first SPLIT cycle coincide ----
      step("race own");
      check("race own fp hmaster", 32'(bus_b.hmaster), 32'd2);
      drive(4'b0100, '0, 2'd0, 3'd0, 1'b0, 2'd3, 4'b0100);
      step("race c1");
      drive(4'b0100, '0, 2'd0, 3'd0, 1'b1, 2'd3, '0);
      step("race c2");
      chk_grant("race c2", 4'b0100, 4'b0001);
      for (int i = 0; i < 2; i++) begin
         drive(4'b0100, '0, 2'd0, 3'd0, 1'b1, 2'd0, '0);
         step($sformatf("race masked%0d", i));
         chk_grant($sformatf("race masked%0d", i), 4'b0100, 4'b0001);
      end
      drive('0, '0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b1111);
      step("race cleanup");

      // ---- asynchronous reset in the middle of an INCR16 ----
      drive(4'b0011, '0, 2'd2, 3'd7, 1'b1, 2'd0, '0);
      step("rst burst0");
      drive(4'b0011, 4'b0001, 2'd3, 3'd7, 1'b1, 2'd0, '0);
      step("rst burst1");
      step("rst burst2");
      async_reset("mid-burst reset");

      // ---- random traffic against the model ----
      for (int c = 0; c < 3000; c++) begin
         int r;
         busreq = N'($urandom);
         hlock  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         htrans = 2'($urandom);
         hburst = 3'($urandom);
         hready = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         hresp  = (r < 7) ? 2'd0 : 2'(r - 6);
         hsplit = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         step($sformatf("rand%0d", c));
         if (c == 1500) async_reset("random reset");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
